// File: rtl/mod_hypothesis_sched.sv
// Hypothesis scheduler: runs diff_square_calc over a QPSK window then an 8-PSK window,
// accumulates returned distances and picks the smaller. Optional macro: SCHED_AUTO_RESTART_EN.
module mod_hypothesis_sched #(
  parameter int LOG2_N    = 4,
  parameter int PIPE_SKIP = 3,
  parameter int DRAIN_TMO = 64
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start_i,
  input  logic                sym_val_i,
  output logic                calc_val_o,
  output logic                calc_enable_o,
  output logic [2:0]          calc_mode_o,
  input  logic                calc_valid_i,
  input  logic [15:0]         calc_sqrt_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  output logic [2:0]          mode_det_o,
  output logic [16+LOG2_N-1:0] metric_qpsk_o,
  output logic [16+LOG2_N-1:0] metric_8psk_o
);

  // state  | meaning
  // IDLE   | waiting for start_i
  // RUN    | gating symbols into the calculator for the current hypothesis
  // DRAIN  | no new symbols; collecting outstanding results, bounded by DRAIN_TMO
  // SWITCH | one cycle: move calculator to 8-PSK and restart window counters
  // DECIDE | one cycle: register metrics and decision, pulse done_o

  localparam int N  = 1 << LOG2_N;
  localparam int CW = LOG2_N + 3;
  localparam int MW = 16 + LOG2_N;
  localparam int TW = $clog2(DRAIN_TMO + 1);

  localparam logic [CW-1:0] WIN_LEN   = CW'(N + PIPE_SKIP);
  localparam logic [CW-1:0] WIN_LAST  = CW'(N + PIPE_SKIP - 1);
  localparam logic [CW-1:0] SKIP_LEN  = CW'(PIPE_SKIP);
  localparam logic [TW-1:0] TMO_LOAD  = TW'(DRAIN_TMO - 1);
  localparam logic [2:0]    MODE_QPSK = 3'b001;
  localparam logic [2:0]    MODE_8PSK = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_SWITCH,
    S_DECIDE
  } state_t;

  state_t state, state_next;

  logic          hyp;
  logic [CW-1:0] issued;
  logic [CW-1:0] returned;
  logic [TW-1:0] tmo_cnt;
  logic [MW-1:0] acc_qpsk;
  logic [MW-1:0] acc_8psk;

  logic gate;
  logic accept;
  logic keep;
  logic win_full;
  logic tmo_hit;
  logic drain_tmo;
  logic start_run;
  logic restart;
  logic enter_drain;

  always_comb begin
    state_next    = state;
    gate          = 1'b0;
    calc_val_o    = 1'b0;
    calc_enable_o = 1'b0;
    start_run     = 1'b0;
    restart       = 1'b0;
    drain_tmo     = 1'b0;
    enter_drain   = 1'b0;
    win_full      = (returned == WIN_LEN);
    tmo_hit       = (tmo_cnt == '0);

    case (state)
      S_IDLE: begin
        if (start_i) begin
          start_run  = 1'b1;
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        calc_enable_o = 1'b1;
        gate          = sym_val_i;
        calc_val_o    = sym_val_i;
        if (sym_val_i && (issued == WIN_LAST)) begin
          enter_drain = 1'b1;
          state_next  = S_DRAIN;
        end
      end
      S_DRAIN: begin
        calc_enable_o = 1'b1;
        if (win_full) begin
          state_next = hyp ? S_DECIDE : S_SWITCH;
        end else if (tmo_hit) begin
          drain_tmo  = 1'b1;
          state_next = S_DECIDE;
        end
      end
      S_SWITCH: begin
        state_next = S_RUN;
      end
      S_DECIDE: begin
`ifdef SCHED_AUTO_RESTART_EN
        if (start_i) begin
          restart    = 1'b1;
          state_next = S_RUN;
        end else begin
          state_next = S_IDLE;
        end
`else
        state_next = S_IDLE;
`endif
      end
      default: state_next = S_IDLE;
    endcase

    // Results arriving after the window is complete are ignored.
    accept = calc_enable_o && calc_valid_i && !win_full;
    keep   = accept && (returned >= SKIP_LEN);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hyp           <= 1'b0;
      issued        <= '0;
      returned      <= '0;
      tmo_cnt       <= '0;
      acc_qpsk      <= '0;
      acc_8psk      <= '0;
      calc_mode_o   <= MODE_QPSK;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      err_o         <= 1'b0;
      mode_det_o    <= 3'b000;
      metric_qpsk_o <= '0;
      metric_8psk_o <= '0;
    end else begin
      done_o <= 1'b0;

      if (gate) begin
        issued <= issued + 1'b1;
      end

      if (enter_drain) begin
        tmo_cnt <= TMO_LOAD;
      end else if ((state == S_DRAIN) && !tmo_hit) begin
        tmo_cnt <= tmo_cnt - 1'b1;
      end

      if (accept) begin
        returned <= returned + 1'b1;
      end

      if (keep) begin
        if (hyp) begin
          acc_8psk <= acc_8psk + {{LOG2_N{1'b0}}, calc_sqrt_i};
        end else begin
          acc_qpsk <= acc_qpsk + {{LOG2_N{1'b0}}, calc_sqrt_i};
        end
      end

      if (drain_tmo) begin
        err_o <= 1'b1;
      end

      if (state == S_SWITCH) begin
        hyp         <= 1'b1;
        calc_mode_o <= MODE_8PSK;
        issued      <= '0;
        returned    <= '0;
      end

      // Ties resolve to QPSK.
      if (state == S_DECIDE) begin
        metric_qpsk_o <= acc_qpsk;
        metric_8psk_o <= acc_8psk;
        mode_det_o    <= (acc_8psk < acc_qpsk) ? MODE_8PSK : MODE_QPSK;
        done_o        <= 1'b1;
        busy_o        <= 1'b0;
      end

      // A new run overrides the DECIDE busy release when auto-restarting.
      if (start_run || restart) begin
        hyp         <= 1'b0;
        calc_mode_o <= MODE_QPSK;
        issued      <= '0;
        returned    <= '0;
        acc_qpsk    <= '0;
        acc_8psk    <= '0;
        err_o       <= 1'b0;
        busy_o      <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mod_hypothesis_sched.sv
// Scoreboard bench for mod_hypothesis_sched with a 4-deep behavioural calculator model.
module tb_mod_hypothesis_sched;

  localparam int LOG2_N    = 4;
  localparam int PIPE_SKIP = 3;
  localparam int N         = 1 << LOG2_N;
  localparam int WIN       = N + PIPE_SKIP;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start_i = 1'b0;
  logic        sym_val_i = 1'b0;
  logic        calc_valid_i = 1'b0;
  logic [15:0] calc_sqrt_i = '0;
  logic        calc_val_o;
  logic        calc_enable_o;
  logic [2:0]  calc_mode_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [2:0]  mode_det_o;
  logic [16+LOG2_N-1:0] metric_qpsk_o;
  logic [16+LOG2_N-1:0] metric_8psk_o;

  mod_hypothesis_sched #(.LOG2_N(LOG2_N), .PIPE_SKIP(PIPE_SKIP), .DRAIN_TMO(64)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start_i(start_i),
    .sym_val_i(sym_val_i),
    .calc_val_o(calc_val_o),
    .calc_enable_o(calc_enable_o),
    .calc_mode_o(calc_mode_o),
    .calc_valid_i(calc_valid_i),
    .calc_sqrt_i(calc_sqrt_i),
    .busy_o(busy_o),
    .done_o(done_o),
    .err_o(err_o),
    .mode_det_o(mode_det_o),
    .metric_qpsk_o(metric_qpsk_o),
    .metric_8psk_o(metric_8psk_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       mq;
    int       m8;
    int       mode;
    int       err;
    int       cq;
    int       c8;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // calculator model controls
  logic [15:0] q_val = '0;
  logic [15:0] p_val = '0;
  int          drop_n = 0;
  int          mq_cnt = 0;

  task automatic chk(input string name, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
    end
  endtask

  // Reference: each hypothesis sums N results; a short QPSK window times out before 8-PSK runs.
  function automatic exp_t predict(input int vq, input int v8, input int drop);
    exp_t e;
    e.mq   = (N - drop) * vq;
    e.m8   = (drop != 0) ? 0 : N * v8;
    e.mode = (e.m8 < e.mq) ? 2 : 1;
    e.err  = (drop != 0) ? 1 : 0;
    e.cq   = WIN;
    e.c8   = (drop != 0) ? 0 : WIN;
    return e;
  endfunction

  // Calculator: constant per-mode result, four cycles after the gated symbol.
  initial begin
    logic        pv[4];
    logic        pm[4];
    logic [15:0] pd[4];
    logic        supp;
    for (int i = 0; i < 4; i++) begin
      pv[i] = 1'b0; pm[i] = 1'b0; pd[i] = '0;
    end
    forever begin
      @(negedge clk);
      supp = 1'b0;
      if (pv[3] && !pm[3]) begin
        mq_cnt++;
        supp = (mq_cnt > WIN - drop_n);
      end
      calc_valid_i = pv[3] && !supp;
      calc_sqrt_i  = pv[3] ? pd[3] : 16'd0;
      for (int i = 3; i > 0; i--) begin
        pv[i] = pv[i-1]; pm[i] = pm[i-1]; pd[i] = pd[i-1];
      end
      pv[0] = calc_val_o;
      pm[0] = (calc_mode_o == 3'b010);
      pd[0] = pm[0] ? p_val : q_val;
    end
  end

  // Monitor: pops the scoreboard on every done_o.
  initial begin
    exp_t e;
    int   cq;
    int   c8;
    bit   prev_done;
    cq = 0; c8 = 0; prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        cq = 0; c8 = 0; prev_done = 1'b0;
      end else begin
        if (calc_val_o) begin
          chk("gate_needs_sym", longint'(sym_val_i), 1);
          if (calc_mode_o == 3'b010) c8++;
          else cq++;
        end
        if (done_o) begin
          chk("done_single_pulse", longint'(prev_done), 0);
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done actual=1 expected=0");
          end else begin
            e = sb.pop_front();
            chk("metric_qpsk", longint'(metric_qpsk_o), e.mq);
            chk("metric_8psk", longint'(metric_8psk_o), e.m8);
            chk("mode_det", longint'(mode_det_o), e.mode);
            chk("err", longint'(err_o), e.err);
            chk("busy_at_done", longint'(busy_o), 0);
            chk("gated_qpsk", cq, e.cq);
            chk("gated_8psk", c8, e.c8);
          end
          cq = 0; c8 = 0;
        end
        prev_done = done_o;
      end
    end
  end

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_calc_val"}, longint'(calc_val_o), 0);
    chk({tag, "_calc_enable"}, longint'(calc_enable_o), 0);
    chk({tag, "_calc_mode"}, longint'(calc_mode_o), 1);
    chk({tag, "_busy"}, longint'(busy_o), 0);
    chk({tag, "_done"}, longint'(done_o), 0);
    chk({tag, "_err"}, longint'(err_o), 0);
    chk({tag, "_mode_det"}, longint'(mode_det_o), 0);
    chk({tag, "_metric_qpsk"}, longint'(metric_qpsk_o), 0);
    chk({tag, "_metric_8psk"}, longint'(metric_8psk_o), 0);
  endtask

  // pat: 0 continuous, 1 alternating, 2 random
  task automatic do_run(input int vq, input int v8, input int pat, input int drop);
    bit seen;
    seen   = 1'b0;
    q_val  = 16'(vq);
    p_val  = 16'(v8);
    drop_n = drop;
    mq_cnt = 0;
    sb.push_back(predict(vq, v8, drop));
    @(posedge clk); #1;
    start_i   = 1'b1;
    sym_val_i = 1'b1;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(posedge clk); #1;
      start_i = (cyc == 8);
      case (pat)
        0:       sym_val_i = 1'b1;
        1:       sym_val_i = ((cyc % 2) == 0);
        default: sym_val_i = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      if (done_o) begin
        seen = 1'b1;
        break;
      end
    end
    start_i   = 1'b0;
    sym_val_i = 1'b0;
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL run_timeout actual=no_done expected=done");
      if (sb.size() > 0) void'(sb.pop_back());
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic reset_mid_8psk();
    int k;
    bit hit;
    k = 0; hit = 1'b0;
    q_val = 16'd10; p_val = 16'd30; drop_n = 0; mq_cnt = 0;
    @(posedge clk); #1;
    start_i   = 1'b1;
    sym_val_i = 1'b1;
    for (int cyc = 0; cyc < 500; cyc++) begin
      @(posedge clk); #1;
      start_i = 1'b0;
      @(negedge clk);
      if (calc_val_o && calc_mode_o == 3'b010) k++;
      if (k == 5) begin
        hit = 1'b1;
        break;
      end
    end
    chk("reached_8psk_run", longint'(hit), 1);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check_idle_outputs("midrun_reset");
    sym_val_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (10) @(posedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    reset_n = 1'b1;
    repeat (3) @(posedge clk);

    do_run(10, 30, 0, 0);
    do_run(40, 25, 0, 0);
    do_run(20, 20, 0, 0);
    do_run(10, 30, 1, 0);
    do_run(10, 30, 0, 2);
    do_run(10, 30, 0, 0);
    reset_mid_8psk();
    do_run(10, 30, 0, 0);
    for (int r = 0; r < 6; r++) begin
      do_run(int'($urandom_range(0, 4000)), int'($urandom_range(0, 4000)),
             int'($urandom_range(0, 2)), 0);
    end

    repeat (5) @(posedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
